// File: rtl/button_reader_if.sv
// Pin and event bundle between the button pins, the button reader and its consumers.
// "release" is a reserved word, so the release event travels on release_evt.
interface button_reader_if;
   logic       btn_1;
   logic       btn_2;
   logic       btn_3;
   logic       btn_4;
   logic [3:0] btn_level;
   logic [3:0] press;
   logic [3:0] release_evt;
   logic [3:0] long_press;
   logic       key_valid;
   logic [1:0] key_code;
   logic       any_held;

   modport master (
      output btn_1, btn_2, btn_3, btn_4,
      input  btn_level, press, release_evt, long_press, key_valid, key_code, any_held
   );

   modport slave (
      input  btn_1, btn_2, btn_3, btn_4,
      output btn_level, press, release_evt, long_press, key_valid, key_code, any_held
   );
endinterface

// File: rtl/button_reader.sv
// Four-channel push-button front end: 2-flop synchroniser, debounce FSM and
// press/release/long-press event pulses per channel, plus an encoded key event.
module button_reader #(
   parameter int unsigned DEBOUNCE_CYCLES = 2500000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic            clk,
   input  logic            rst,
   button_reader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_e;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [3:0]       pin;
   logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
   state_e           state_q [4];
   state_e           state_d [4];
   logic [CNT_W-1:0] dcnt_q [4];
   logic [CNT_W-1:0] dcnt_d [4];
   logic [CNT_W-1:0] hcnt_q [4];
   logic [CNT_W-1:0] hcnt_d [4];
   logic [3:0]       long_done_q, long_done_d;
   logic [3:0]       level_q, level_d;
   logic [3:0]       press_q, press_d;
   logic [3:0]       rel_q, rel_d;
   logic [3:0]       long_q, long_d;
   logic             key_valid_q, key_valid_d;
   logic [1:0]       key_code_q, key_code_d;

   assign pin     = {bus.btn_4, bus.btn_3, bus.btn_2, bus.btn_1};
   assign sync1_d = pin;
   assign sync2_d = sync1_q;

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         state_d[i]     = state_q[i];
         dcnt_d[i]      = dcnt_q[i];
         hcnt_d[i]      = hcnt_q[i];
         long_done_d[i] = long_done_q[i];
         press_d[i]     = 1'b0;
         rel_d[i]       = 1'b0;
         long_d[i]      = 1'b0;
         unique case (state_q[i])
            IDLE: begin
               if (sync2_q[i]) begin
                  state_d[i] = DEB_PRESS;
                  dcnt_d[i]  = ONE;
               end
            end
            DEB_PRESS: begin
               if (!sync2_q[i]) begin
                  state_d[i] = IDLE;
               end else if (dcnt_q[i] == DEB_LAST) begin
                  state_d[i]     = HELD;
                  press_d[i]     = 1'b1;
                  hcnt_d[i]      = '0;
                  long_done_d[i] = 1'b0;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + ONE;
               end
            end
            HELD: begin
               if (!sync2_q[i]) begin
                  state_d[i] = DEB_RELEASE;
                  dcnt_d[i]  = ONE;
               end else begin
                  hcnt_d[i] = (hcnt_q[i] == LONG_MAX) ? hcnt_q[i] : hcnt_q[i] + ONE;
               end
            end
            DEB_RELEASE: begin
               // hold time keeps running while a release is being qualified
               hcnt_d[i] = (hcnt_q[i] == LONG_MAX) ? hcnt_q[i] : hcnt_q[i] + ONE;
               if (sync2_q[i]) begin
                  state_d[i] = HELD;
               end else if (dcnt_q[i] == DEB_LAST) begin
                  state_d[i] = IDLE;
                  rel_d[i]   = 1'b1;
               end else begin
                  dcnt_d[i] = dcnt_q[i] + ONE;
               end
            end
            default: state_d[i] = IDLE;
         endcase
         if ((state_q[i] == HELD || state_q[i] == DEB_RELEASE) &&
             hcnt_d[i] == LONG_MAX && !long_done_q[i]) begin
            long_d[i]      = 1'b1;
            long_done_d[i] = 1'b1;
         end
         level_d[i] = (state_d[i] == HELD) || (state_d[i] == DEB_RELEASE);
      end
      key_valid_d = |press_d;
      key_code_d  = key_code_q;
      for (int unsigned i = 4; i > 0; i--) begin
         if (press_d[i-1]) key_code_d = 2'(i - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         long_done_q <= '0;
         level_q     <= '0;
         press_q     <= '0;
         rel_q       <= '0;
         long_q      <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            state_q[i] <= IDLE;
            dcnt_q[i]  <= '0;
            hcnt_q[i]  <= '0;
         end
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         long_q      <= long_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         for (int unsigned i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            dcnt_q[i]  <= dcnt_d[i];
            hcnt_q[i]  <= hcnt_d[i];
         end
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.press       = press_q;
   assign bus.release_evt = rel_q;
   assign bus.long_press  = long_q;
   assign bus.key_valid   = key_valid_q;
   assign bus.key_code    = key_code_q;
   assign bus.any_held    = |level_q;
endmodule
